// File: rtl/add4_arbiter_if.sv
// rtl/add4_arbiter_if.sv - requester/consumer handshake bundle for the shared-adder arbiter
// master drives operands and resp_ready; slave is the arbiter side.
interface add4_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_ready;
    logic [WIDTH-1:0] req_a [NREQ];
    logic [WIDTH-1:0] req_b [NREQ];

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_sum;
    logic             resp_carry;
    logic [IDW-1:0]   resp_id;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_sum, resp_carry, resp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_sum, resp_carry, resp_id
    );
endinterface

// File: rtl/add4_arbiter.sv
// rtl/add4_arbiter.sv - round-robin scheduler sharing one WIDTH-bit adder among NREQ requesters
// One-deep registered result stage; a drain and a refill may happen on the same edge.
module add4_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    add4_arbiter_if.slave      bus
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]   r_prio;
    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [IDW-1:0]   r_id;

    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic             w_can_accept;
    logic             w_accept;
    logic [NREQ-1:0]  w_ready;
    logic [WIDTH:0]   w_sum_full;
    logic [IDW-1:0]   w_prio_nxt;

    // Modulo-NREQ increment that also wraps correctly for non-power-of-2 NREQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && bus.req_valid[wrap_add(r_prio, i)]) begin
                w_found = 1'b1;
                w_win   = wrap_add(r_prio, i);
            end
        end
    end

    // rst_n gates the grant so req_ready is low while reset is held.
    assign w_can_accept = !r_valid || bus.resp_ready;
    assign w_accept     = rst_n && w_found && w_can_accept;

    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_win] = 1'b1;
        end
    end

    assign w_sum_full = {1'b0, bus.req_a[w_win]} + {1'b0, bus.req_b[w_win]};
    assign w_prio_nxt = wrap_add(w_win, 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio  <= '0;
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_id    <= '0;
        end else if (w_accept) begin
            r_prio  <= w_prio_nxt;
            r_valid <= 1'b1;
            r_sum   <= w_sum_full[WIDTH-1:0];
            r_carry <= w_sum_full[WIDTH];
            r_id    <= w_win;
        end else if (bus.resp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_valid;
    assign bus.resp_sum   = r_sum;
    assign bus.resp_carry = r_carry;
    assign bus.resp_id    = r_id;
endmodule

// File: tb/tb_add4_arbiter.sv
// tb/tb_add4_arbiter.sv - scoreboard bench for add4_arbiter with directed vectors
module tb_add4_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add4_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
    add4_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int sum;
        int carry;
        int id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int sum, input int carry, input int id);
        exp_t e;
        e.sum   = sum;
        e.carry = carry;
        e.id    = id;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        bus.req_a[i] = WIDTH'(a);
        bus.req_b[i] = WIDTH'(b);
    endtask

    exp_t m_e;
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                m_e = sb.pop_front();
                chk("resp_sum", int'(bus.resp_sum), m_e.sum);
                chk("resp_carry", int'(bus.resp_carry), m_e.carry);
                chk("resp_id", int'(bus.resp_id), m_e.id);
            end
        end
    end

    int rr_sum [4] = '{3, 7, 11, 2};
    int rr_car [4] = '{0, 0, 0, 1};

    initial begin
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 0, 0);

        // reset state, requests pending must not be granted
        bus.req_valid = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(bus.resp_valid), 0);
        chk("rst_sum", int'(bus.resp_sum), 0);
        chk("rst_carry", int'(bus.resp_carry), 0);
        chk("rst_id", int'(bus.resp_id), 0);
        chk("rst_ready", int'(bus.req_ready), 0);
        bus.req_valid = '0;
        rst_n = 1'b1;

        // single add
        set_ops(0, 2, 12);
        bus.req_valid  = 4'b0001;
        bus.resp_ready = 1'b1;
        #1 chk("single_rdy", int'(bus.req_ready), 1);
        push(14, 0, 0);
        step();
        chk("latency_valid", int'(bus.resp_valid), 1);
        bus.req_valid = '0;

        // overflow wrap
        set_ops(2, 12, 5);
        bus.req_valid = 4'b0100;
        #1 chk("ovf1_rdy", int'(bus.req_ready), 4);
        push(1, 1, 2);
        step();
        set_ops(2, 15, 1);
        #1 chk("ovf2_rdy", int'(bus.req_ready), 4);
        push(0, 1, 2);
        step();

        // bring prio back to 0 via requester 3
        set_ops(3, 1, 1);
        bus.req_valid = 4'b1000;
        #1 chk("pre_rr_rdy", int'(bus.req_ready), 8);
        push(2, 0, 3);
        step();

        // round-robin with all requesters held
        set_ops(0, 1, 2);
        set_ops(1, 3, 4);
        set_ops(2, 5, 6);
        set_ops(3, 9, 9);
        bus.req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_rdy", int'(bus.req_ready), 1 << (k % 4));
            chk("rr_onehot", int'($onehot(bus.req_ready)), 1);
            push(rr_sum[k % 4], rr_car[k % 4], k % 4);
            step();
        end

        // backpressure: output holds id1 (sum 7), prio is 2
        bus.req_valid  = 4'b1010;
        bus.resp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_rdy", int'(bus.req_ready), 0);
            chk("bp_valid", int'(bus.resp_valid), 1);
            chk("bp_id", int'(bus.resp_id), 1);
            chk("bp_sum", int'(bus.resp_sum), 7);
            step();
        end
        bus.resp_ready = 1'b1;
        #1 chk("bp_release_rdy", int'(bus.req_ready), 8);
        push(2, 1, 3);
        step();
        chk("no_bubble_valid", int'(bus.resp_valid), 1);
        chk("no_bubble_id", int'(bus.resp_id), 3);
        bus.req_valid = 4'b0010;
        #1 chk("bp_next_rdy", int'(bus.req_ready), 2);
        push(7, 0, 1);
        step();

        // sparse wrap 3 -> 0 -> 1, then idle gap
        bus.req_valid = 4'b1000;
        #1 chk("sparse3_rdy", int'(bus.req_ready), 8);
        push(2, 1, 3);
        step();
        bus.req_valid = 4'b0001;
        #1 chk("sparse0_rdy", int'(bus.req_ready), 1);
        push(3, 0, 0);
        step();
        bus.req_valid = '0;
        repeat (10) step();
        bus.req_valid = 4'b0011;
        #1 chk("prio_hold_rdy", int'(bus.req_ready), 2);
        push(7, 0, 1);
        step();
        bus.req_valid = '0;
        step();

        // reset while a result is stalled
        bus.resp_ready = 1'b0;
        set_ops(2, 7, 7);
        bus.req_valid = 4'b0100;
        #1 chk("stall_load_rdy", int'(bus.req_ready), 4);
        push(14, 0, 2);
        step();
        bus.req_valid = '0;
        step();
        chk("stall_valid", int'(bus.resp_valid), 1);
        chk("stall_sum", int'(bus.resp_sum), 14);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(bus.resp_valid), 0);
        chk("mid_rst_sum", int'(bus.resp_sum), 0);
        chk("mid_rst_carry", int'(bus.resp_carry), 0);
        chk("mid_rst_id", int'(bus.resp_id), 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req_valid  = 4'b0110;
        bus.resp_ready = 1'b1;
        #1 chk("post_rst_rdy", int'(bus.req_ready), 2);
        push(7, 0, 1);
        step();
        bus.req_valid = '0;
        repeat (3) step();
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
